// File: rtl/fb_arbiter_pkg.sv
// Shared types and constants for the frame-buffer capture arbiter.
package fb_arbiter_pkg;

    localparam int FB_SIZE_DEF = 19200;
    localparam int PIX_W       = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/fb_arbiter_if.sv
// Camera write stream, reader port and single-port RAM bus of the arbiter.
interface fb_arbiter_if #(
    parameter int AW = 15
) ();
    import fb_arbiter_pkg::*;

    logic             cam_vsync;
    logic             cam_wr;
    logic [AW-1:0]    cam_addr;
    logic [PIX_W-1:0] cam_data;

    logic             rd_req;
    logic [AW-1:0]    rd_addr;
    logic             rd_ack;
    logic [PIX_W-1:0] rd_data;

    logic [AW-1:0]    mem_addr;
    logic [PIX_W-1:0] mem_wdata;
    logic             mem_we;
    logic [PIX_W-1:0] mem_rdata;

    modport master (
        input  cam_vsync, cam_wr, cam_addr, cam_data,
        input  rd_req, rd_addr, mem_rdata,
        output rd_ack, rd_data, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        output cam_vsync, cam_wr, cam_addr, cam_data,
        output rd_req, rd_addr, mem_rdata,
        input  rd_ack, rd_data, mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/fb_rd_port.sv
// Reader grant and ack pipeline: grant only in a cycle without a camera write,
// one request in flight, ack two cycles after the RAM address cycle.
module fb_rd_port
    import fb_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_issue,
    input  logic             rd_req,
    input  logic [PIX_W-1:0] mem_rdata,
    output logic             grant,
    output logic             rd_ack,
    output logic [PIX_W-1:0] rd_data
);

    logic addr_cyc;
    logic data_cyc;

    // rd_req is only looked at again once the previous ack has gone out
    assign grant = rd_req & ~wr_issue & ~(addr_cyc | data_cyc | rd_ack);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_cyc <= 1'b0;
            data_cyc <= 1'b0;
            rd_ack   <= 1'b0;
            rd_data  <= '0;
        end else begin
            addr_cyc <= grant;
            data_cyc <= addr_cyc;
            rd_ack   <= data_cyc;
            if (data_cyc) begin
                rd_data <= mem_rdata;
            end
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer capture controller: camera-priority RAM arbiter with a
// start/arm/capture/done sequencer and a pipelined reader port.
module fb_arbiter
    import fb_arbiter_pkg::*;
#(
    parameter int AW      = 15,
    parameter int FB_SIZE = FB_SIZE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic cap_start,
    input  logic cap_abort,
    output logic cap_busy,
    output logic cap_done,
    output logic cap_short,
    fb_arbiter_if.master bus
);

    localparam int             CW       = $clog2(FB_SIZE + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FB_SIZE - 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(FB_SIZE);
    localparam logic [31:0]    FB_LIM   = 32'(FB_SIZE);

    state_t           state;
    logic [CW-1:0]    wr_cnt;
    logic             vsync_q;
    logic             vsync_rise;
    logic             cam_accept;
    logic             rd_grant;
    logic             mem_we_q;
    logic [AW-1:0]    mem_addr_q;
    logic [PIX_W-1:0] mem_wdata_q;

    assign vsync_rise = bus.cam_vsync & ~vsync_q;
    assign cam_accept = (state == S_CAPTURE) & bus.cam_wr & ~cap_abort
                      & (32'(bus.cam_addr) < FB_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            wr_cnt    <= '0;
            vsync_q   <= 1'b1;
            cap_busy  <= 1'b0;
            cap_done  <= 1'b0;
            cap_short <= 1'b0;
        end else begin
            vsync_q <= bus.cam_vsync;
            if (cam_accept && wr_cnt != CNT_MAX) begin
                wr_cnt <= wr_cnt + CW'(1);
            end
            if (cap_abort) begin
                state     <= S_IDLE;
                cap_busy  <= 1'b0;
                cap_done  <= 1'b0;
                cap_short <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cap_start) begin
                            state    <= S_ARM;
                            cap_busy <= 1'b1;
                        end
                    end
                    S_ARM: begin
                        if (vsync_rise) begin
                            state  <= S_CAPTURE;
                            wr_cnt <= '0;
                        end
                    end
                    S_CAPTURE: begin
                        // a final write landing on the vsync edge is a full frame
                        if (cam_accept && wr_cnt == CNT_LAST) begin
                            state     <= S_DONE;
                            cap_busy  <= 1'b0;
                            cap_done  <= 1'b1;
                            cap_short <= 1'b0;
                        end else if (vsync_rise) begin
                            state     <= S_DONE;
                            cap_busy  <= 1'b0;
                            cap_done  <= 1'b1;
                            cap_short <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (cap_start) begin
                            state     <= S_ARM;
                            cap_busy  <= 1'b1;
                            cap_done  <= 1'b0;
                            cap_short <= 1'b0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (cam_accept) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= bus.cam_addr;
            mem_wdata_q <= bus.cam_data;
        end else begin
            mem_we_q <= 1'b0;
            if (rd_grant) begin
                mem_addr_q <= bus.rd_addr;
            end
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    fb_rd_port u_rd_port (
        .clk       (clk),
        .rst       (rst),
        .wr_issue  (cam_accept),
        .rd_req    (bus.rd_req),
        .mem_rdata (bus.mem_rdata),
        .grant     (rd_grant),
        .rd_ack    (bus.rd_ack),
        .rd_data   (bus.rd_data)
    );

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural 1-cycle-latency RAM.
module tb_fb_arbiter;

    logic clk;
    logic rst;
    logic cap_start;
    logic cap_abort;
    logic cap_busy;
    logic cap_done;
    logic cap_short;

    int vectors     = 0;
    int miscompares = 0;
    int we_cnt      = 0;
    int we_base;
    bit ack_seen;

    logic [7:0] ram [0:32767];

    fb_arbiter_if #(.AW(15)) b ();

    fb_arbiter #(.AW(15), .FB_SIZE(19200)) dut (
        .clk       (clk),
        .rst       (rst),
        .cap_start (cap_start),
        .cap_abort (cap_abort),
        .cap_busy  (cap_busy),
        .cap_done  (cap_done),
        .cap_short (cap_short),
        .bus       (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (b.mem_we === 1'b1) begin
            ram[b.mem_addr] <= b.mem_wdata;
            we_cnt <= we_cnt + 1;
        end
        b.mem_rdata <= ram[b.mem_addr];
    end

    function automatic logic [7:0] pix(input int a);
        return 8'(a * 7 + 3);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic vsync_rise_to_capture();
        b.cam_vsync = 1'b0;
        tick();
        b.cam_vsync = 1'b1;
        tick();
    endtask

    initial begin
        rst         = 1'b0;
        cap_start   = 1'b0;
        cap_abort   = 1'b0;
        b.cam_vsync = 1'b1;
        b.cam_wr    = 1'b0;
        b.cam_addr  = '0;
        b.cam_data  = '0;
        b.rd_req    = 1'b0;
        b.rd_addr   = '0;
        #23;
        chk("rst_busy",    32'(cap_busy), 0);
        chk("rst_done",    32'(cap_done), 0);
        chk("rst_short",   32'(cap_short), 0);
        chk("rst_we",      32'(b.mem_we), 0);
        chk("rst_ack",     32'(b.rd_ack), 0);
        chk("rst_addr",    32'(b.mem_addr), 0);
        chk("rst_wdata",   32'(b.mem_wdata), 0);
        chk("rst_rdata",   32'(b.rd_data), 0);
        chk("rst_vsync_q", 32'(dut.vsync_q), 1);
        tick();
        rst = 1'b1;

        // camera writes while idle are dropped
        we_base    = we_cnt;
        b.cam_wr   = 1'b1;
        b.cam_addr = 15'd5;
        tick(); tick(); tick();
        b.cam_wr = 1'b0;
        tick();
        chk("idle_drop_we", 32'(we_cnt - we_base), 0);
        chk("idle_busy",    32'(cap_busy), 0);

        // full frame
        cap_start = 1'b1;
        tick();
        cap_start = 1'b0;
        chk("arm_busy", 32'(cap_busy), 1);
        vsync_rise_to_capture();
        chk("cap_busy", 32'(cap_busy), 1);
        we_base = we_cnt;
        for (int i = 0; i < 19200; i++) begin
            b.cam_wr   = 1'b1;
            b.cam_addr = 15'(i);
            b.cam_data = pix(i);
            tick();
            if (i == 0) begin
                chk("wr_lat_we",   32'(b.mem_we), 1);
                chk("wr_lat_addr", 32'(b.mem_addr), 0);
                chk("wr_lat_data", 32'(b.mem_wdata), 32'(pix(0)));
                chk("first_done",  32'(cap_done), 0);
            end
        end
        b.cam_wr = 1'b0;
        chk("full_done",  32'(cap_done), 1);
        chk("full_short", 32'(cap_short), 0);
        chk("full_busy",  32'(cap_busy), 0);
        chk("full_last_addr", 32'(b.mem_addr), 19199);
        tick();
        chk("full_we_cnt", 32'(we_cnt - we_base), 19200);

        // short frame with a reader held off by continuous writes
        cap_start = 1'b1;
        tick();
        cap_start = 1'b0;
        chk("rearm_done",  32'(cap_done), 0);
        chk("rearm_busy",  32'(cap_busy), 1);
        vsync_rise_to_capture();
        we_base   = we_cnt;
        ack_seen  = 1'b0;
        b.rd_req  = 1'b1;
        b.rd_addr = 15'd300;
        for (int i = 0; i < 100; i++) begin
            b.cam_wr   = 1'b1;
            b.cam_addr = 15'(1000 + i);
            b.cam_data = pix(1000 + i);
            tick();
            if (b.rd_ack === 1'b1) ack_seen = 1'b1;
        end
        chk("no_ack_during_writes", 32'(ack_seen), 0);
        b.cam_wr    = 1'b0;
        b.cam_vsync = 1'b0;
        tick();
        chk("gap_we",   32'(b.mem_we), 0);
        chk("gap_addr", 32'(b.mem_addr), 300);
        chk("gap_ack",  32'(b.rd_ack), 0);
        tick();
        chk("gap1_ack", 32'(b.rd_ack), 0);
        b.cam_vsync = 1'b1;
        tick();
        chk("rd_ack",     32'(b.rd_ack), 1);
        chk("rd_data",    32'(b.rd_data), 32'(pix(300)));
        chk("short_done", 32'(cap_done), 1);
        chk("short_flag", 32'(cap_short), 1);
        chk("short_busy", 32'(cap_busy), 0);
        b.rd_req = 1'b0;
        tick();
        chk("ack_pulse",    32'(b.rd_ack), 0);
        chk("short_we_cnt", 32'(we_cnt - we_base), 100);

        // read back a pixel of the short frame while in DONE
        b.rd_req  = 1'b1;
        b.rd_addr = 15'd1050;
        tick();
        chk("done_rd_addr", 32'(b.mem_addr), 1050);
        tick();
        chk("done_rd_wait", 32'(b.rd_ack), 0);
        tick();
        chk("done_rd_ack",  32'(b.rd_ack), 1);
        chk("done_rd_data", 32'(b.rd_data), 32'(pix(1050)));
        b.rd_req = 1'b0;
        tick();

        // out-of-range address during capture is dropped uncounted
        cap_start = 1'b1;
        tick();
        cap_start = 1'b0;
        vsync_rise_to_capture();
        we_base    = we_cnt;
        b.cam_wr   = 1'b1;
        b.cam_addr = 15'd19200;
        tick(); tick(); tick();
        b.cam_wr = 1'b0;
        tick();
        chk("oor_we_cnt", 32'(we_cnt - we_base), 0);
        chk("oor_wr_cnt", 32'(dut.wr_cnt), 0);
        b.cam_wr   = 1'b1;
        b.cam_addr = 15'd5;
        b.cam_data = 8'hA5;
        tick();
        b.cam_wr = 1'b0;
        chk("inr_we",   32'(b.mem_we), 1);
        chk("inr_addr", 32'(b.mem_addr), 5);
        tick();
        chk("inr_wr_cnt", 32'(dut.wr_cnt), 1);

        // abort beats start
        cap_abort = 1'b1;
        cap_start = 1'b1;
        tick();
        cap_abort = 1'b0;
        cap_start = 1'b0;
        chk("abort_busy",  32'(cap_busy), 0);
        chk("abort_done",  32'(cap_done), 0);
        chk("abort_short", 32'(cap_short), 0);
        tick();
        chk("abort_stays_idle", 32'(cap_busy), 0);
        cap_start = 1'b1;
        tick();
        cap_start = 1'b0;
        chk("restart_busy", 32'(cap_busy), 1);
        vsync_rise_to_capture();
        b.cam_wr   = 1'b1;
        b.cam_addr = 15'd9;
        tick();
        chk("restart_we", 32'(b.mem_we), 1);
        b.cam_addr = 15'd10;

        // reset in the middle of a capture with vsync held high
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_we",      32'(b.mem_we), 0);
        chk("mid_rst_busy",    32'(cap_busy), 0);
        chk("mid_rst_addr",    32'(b.mem_addr), 0);
        chk("mid_rst_vsync_q", 32'(dut.vsync_q), 1);
        tick(); tick();
        rst      = 1'b1;
        b.cam_wr = 1'b0;
        tick();
        chk("post_rst_busy",  32'(cap_busy), 0);
        chk("post_rst_done",  32'(cap_done), 0);
        chk("post_rst_short", 32'(cap_short), 0);
        chk("post_rst_ack",   32'(b.rd_ack), 0);
        we_base   = we_cnt;
        cap_start = 1'b1;
        tick();
        cap_start  = 1'b0;
        b.cam_wr   = 1'b1;
        b.cam_addr = 15'd3;
        tick(); tick();
        b.cam_wr = 1'b0;
        tick();
        chk("no_false_edge_we",   32'(we_cnt - we_base), 0);
        chk("no_false_edge_busy", 32'(cap_busy), 1);
        chk("no_false_edge_state", 32'(dut.state), 32'(fb_arbiter_pkg::S_ARM));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
